order_stream_assembler: RTL and testbench
=========================================

Name: order_stream_assembler

Overview:
- Upstream neighbour of the order cache stage. Receives the accelerator instruction stream as 32-bit beats from the instruction DMA, eight beats per order.
- Assembles each 256-bit order, checks framing and the sync tag, then unpacks it into the per-field x_* bundle.
- Pushes each good order into the order cache with a single-cycle push_order_en, honouring order_in_ready.
- Malformed orders are dropped and counted; no partial order ever reaches the cache.

Parameters:
- TAG_CHECK_EN, 1, 1 = enforce sync tag in bits [255:248]; 0 = ignore the tag.
- SYNC_TAG, 8'hA5, required value of bits [255:248].

Ports:
- clk  input  1  clock, sole clock domain.
- srst  input  1  synchronous reset, active-high.
- s_word  input  32  instruction beat; beat k carries order bits [32k+31:32k].
- s_valid  input  1  beat valid.
- s_last  input  1  marks beat 7 of an order.
- s_ready  output  1  beat accepted when s_valid & s_ready.
- order_in_ready  input  1  order cache can take a push.
- push_order_en  output  1  one-cycle push strobe; x_* are valid while it is high.
- x_order 3, x_feature_input_base_addr 32, x_feature_input_patch_num 8, x_feature_output_patch_num 8, x_feature_double_patch 1, x_feature_patch_num 32: outputs, order fields.
- x_row_size 10, x_col_size 10, x_weight_quant_size 4, x_fea_in_quant_size 4, x_fea_out_quant_size 4, x_stride 1: outputs, order fields.
- x_return_addr 32, x_return_patch_num 16, x_padding_size 3, x_weight_data_length 32, x_activate 1, x_id 32: outputs, order fields.
- orders_pushed  output  32  count of pushed orders; wraps.
- err_count  output  16  count of dropped orders; saturates at 16'hFFFF.
- err_pulse  output  1  one-cycle strobe per dropped order.
- busy  output  1  high when not in COLLECT with beat index 0.

Behaviour:
- Bit layout (LSB first):
  - order[2:0], base_addr[34:3], in_patch[42:35], out_patch[50:43], double[51], patch_num[83:52]
  - row[93:84], col[103:94], wq[107:104], fiq[111:108], foq[115:112], stride[116]
  - ret_addr[148:117], ret_patch[164:149], padding[167:165], wlen[199:168], activate[200], id[232:201]
  - reserved[247:233] (ignored), tag[255:248].
- States: COLLECT, PUSH, DISCARD.
- 3-bit beat index idx; beat shift register sr[255:0].
- COLLECT:
  - s_ready=1. On each accepted beat, sr[32*idx +: 32] <= s_word.
  - s_last && idx<7: frame error, idx<=0, stay COLLECT.
  - idx==7 && !s_last: frame error, go DISCARD.
  - idx==7 && s_last && tag bad (only when TAG_CHECK_EN): tag error, idx<=0, stay COLLECT.
  - idx==7 && s_last && tag ok: latch x_* from the unpacked order, go PUSH.
  - Otherwise idx<=idx+1.
- PUSH:
  - s_ready=0; x_* held stable.
  - push_order_en = order_in_ready (combinational from state and input).
  - When order_in_ready=1: orders_pushed++, idx<=0, go COLLECT.
  - Earliest push is the cycle after the last beat is accepted. Back-to-back throughput is 9 cycles per order.
- DISCARD: s_ready=1; drop beats until a beat with s_last is accepted, then idx<=0 and go COLLECT.
- Each error (frame or tag) raises err_pulse for exactly one cycle the following cycle and increments err_count once per order, saturating at 16'hFFFF.
- srst, including mid-order or mid-PUSH:
  - State COLLECT, idx=0, sr=0, all x_*=0.
  - orders_pushed=0, err_count=0, err_pulse=0.
  - No push in the reset cycle; any partial order is lost.
- s_valid low: no state change. A beat is never accepted in PUSH.
- order_in_ready toggling while in PUSH: exactly one push per order.

Decomposition:
- Package order_pkg: field LSB/width localparams, ORDER_BITS=256, WORDS_PER_ORDER=8, default SYNC_TAG, and the state encoding.
- The same package constants are used by the order cache packing so both sides agree on the layout.
- One combinational sub-module, order_word_unpack: 256-bit word in, x_* fields and tag out. It is reusable by the verification bench's scoreboard.

Test Plan:
1. One good order (tag A5, order=3'd2, id=32'h12345678, row=10'd416), s_valid held high, order_in_ready=1 -> push_order_en high exactly 1 cycle, one cycle after beat 7; x_* match; orders_pushed=1.
2. Same order with order_in_ready=0 for 5 cycles after assembly -> s_ready=0 and x_* stable throughout; single push on the first ready cycle.
3. Tag 8'h5A with TAG_CHECK_EN=1 -> no push; err_pulse once; err_count=1. A following good order pushes normally. Repeat with TAG_CHECK_EN=0 -> order is pushed.
4. s_last on beat 4 -> err_count=1; the next 8 beats form a good order that is pushed. Separately, s_last absent on beat 7 and present on beat 11 -> beats 8–11 dropped, err_count=1, resync on beat 12.
5. srst asserted after 3 beats of an order -> all outputs 0, no push. A new full order afterwards pushes with orders_pushed=1.
6. Ten back-to-back good orders with s_valid and order_in_ready constant -> 10 pushes spaced exactly 9 cycles apart; ids in order; err_count=0.

Source files
------------

// File: rtl/order_pkg.sv
// Order word layout, framing constants and assembler state encoding, shared by
// the stream assembler and the order cache packing so both agree on bit positions.
package order_pkg;

    localparam int ORDER_BITS      = 256;
    localparam int WORDS_PER_ORDER = 8;
    localparam int WORD_BITS       = 32;
    localparam int IDX_BITS        = 3;

    localparam logic [7:0] DEFAULT_SYNC_TAG = 8'hA5;

    localparam int ORDER_LSB     = 0;    localparam int ORDER_W     = 3;
    localparam int BASE_ADDR_LSB = 3;    localparam int BASE_ADDR_W = 32;
    localparam int IN_PATCH_LSB  = 35;   localparam int IN_PATCH_W  = 8;
    localparam int OUT_PATCH_LSB = 43;   localparam int OUT_PATCH_W = 8;
    localparam int DOUBLE_LSB    = 51;
    localparam int PATCH_NUM_LSB = 52;   localparam int PATCH_NUM_W = 32;
    localparam int ROW_LSB       = 84;   localparam int ROW_W       = 10;
    localparam int COL_LSB       = 94;   localparam int COL_W       = 10;
    localparam int WQ_LSB        = 104;  localparam int QUANT_W     = 4;
    localparam int FIQ_LSB       = 108;
    localparam int FOQ_LSB       = 112;
    localparam int STRIDE_LSB    = 116;
    localparam int RET_ADDR_LSB  = 117;  localparam int RET_ADDR_W  = 32;
    localparam int RET_PATCH_LSB = 149;  localparam int RET_PATCH_W = 16;
    localparam int PADDING_LSB   = 165;  localparam int PADDING_W   = 3;
    localparam int WLEN_LSB      = 168;  localparam int WLEN_W      = 32;
    localparam int ACTIVATE_LSB  = 200;
    localparam int ID_LSB        = 201;  localparam int ID_W        = 32;
    localparam int RSVD_LSB      = 233;  localparam int RSVD_W      = 15;
    localparam int TAG_LSB       = 248;  localparam int TAG_W       = 8;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PUSH    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic                   activate;
        logic [WLEN_W-1:0]      wlen;
        logic [PADDING_W-1:0]   padding;
        logic [RET_PATCH_W-1:0] ret_patch;
        logic [RET_ADDR_W-1:0]  ret_addr;
        logic                   stride;
        logic [QUANT_W-1:0]     foq;
        logic [QUANT_W-1:0]     fiq;
        logic [QUANT_W-1:0]     wq;
        logic [COL_W-1:0]       col;
        logic [ROW_W-1:0]       row;
        logic [PATCH_NUM_W-1:0] patch_num;
        logic                   dbl;
        logic [OUT_PATCH_W-1:0] out_patch;
        logic [IN_PATCH_W-1:0]  in_patch;
        logic [BASE_ADDR_W-1:0] base_addr;
        logic [ORDER_W-1:0]     order;
    } order_fields_t;

endpackage

// File: rtl/order_word_unpack.sv
// Pure combinational split of a 256-bit order word into its fields and sync tag.
// Zero latency, no flow control; reserved bits are ignored.
module order_word_unpack
    import order_pkg::*;
(
    input  logic [ORDER_BITS-1:0]  word_i,
    output logic [ORDER_W-1:0]     order_o,
    output logic [BASE_ADDR_W-1:0] base_addr_o,
    output logic [IN_PATCH_W-1:0]  in_patch_o,
    output logic [OUT_PATCH_W-1:0] out_patch_o,
    output logic                   double_o,
    output logic [PATCH_NUM_W-1:0] patch_num_o,
    output logic [ROW_W-1:0]       row_o,
    output logic [COL_W-1:0]       col_o,
    output logic [QUANT_W-1:0]     wq_o,
    output logic [QUANT_W-1:0]     fiq_o,
    output logic [QUANT_W-1:0]     foq_o,
    output logic                   stride_o,
    output logic [RET_ADDR_W-1:0]  ret_addr_o,
    output logic [RET_PATCH_W-1:0] ret_patch_o,
    output logic [PADDING_W-1:0]   padding_o,
    output logic [WLEN_W-1:0]      wlen_o,
    output logic                   activate_o,
    output logic [ID_W-1:0]        id_o,
    output logic [TAG_W-1:0]       tag_o
);

    logic unused_rsvd;

    assign order_o     = word_i[ORDER_LSB     +: ORDER_W];
    assign base_addr_o = word_i[BASE_ADDR_LSB +: BASE_ADDR_W];
    assign in_patch_o  = word_i[IN_PATCH_LSB  +: IN_PATCH_W];
    assign out_patch_o = word_i[OUT_PATCH_LSB +: OUT_PATCH_W];
    assign double_o    = word_i[DOUBLE_LSB];
    assign patch_num_o = word_i[PATCH_NUM_LSB +: PATCH_NUM_W];
    assign row_o       = word_i[ROW_LSB       +: ROW_W];
    assign col_o       = word_i[COL_LSB       +: COL_W];
    assign wq_o        = word_i[WQ_LSB        +: QUANT_W];
    assign fiq_o       = word_i[FIQ_LSB       +: QUANT_W];
    assign foq_o       = word_i[FOQ_LSB       +: QUANT_W];
    assign stride_o    = word_i[STRIDE_LSB];
    assign ret_addr_o  = word_i[RET_ADDR_LSB  +: RET_ADDR_W];
    assign ret_patch_o = word_i[RET_PATCH_LSB +: RET_PATCH_W];
    assign padding_o   = word_i[PADDING_LSB   +: PADDING_W];
    assign wlen_o      = word_i[WLEN_LSB      +: WLEN_W];
    assign activate_o  = word_i[ACTIVATE_LSB];
    assign id_o        = word_i[ID_LSB        +: ID_W];
    assign tag_o       = word_i[TAG_LSB       +: TAG_W];
    assign unused_rsvd = ^word_i[RSVD_LSB +: RSVD_W];

endmodule

// File: rtl/order_stream_assembler.sv
// Assembles 8x32-bit beats into a checked order and pushes it to the order cache.
// Push one cycle after the last beat; beats stall (s_ready=0) while a push awaits order_in_ready.
module order_stream_assembler
    import order_pkg::*;
#(
    parameter bit         TAG_CHECK_EN = 1'b1,
    parameter logic [7:0] SYNC_TAG     = DEFAULT_SYNC_TAG
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [31:0] s_word,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        order_in_ready,
    output logic        push_order_en,
    output logic [2:0]  x_order,
    output logic [31:0] x_feature_input_base_addr,
    output logic [7:0]  x_feature_input_patch_num,
    output logic [7:0]  x_feature_output_patch_num,
    output logic        x_feature_double_patch,
    output logic [31:0] x_feature_patch_num,
    output logic [9:0]  x_row_size,
    output logic [9:0]  x_col_size,
    output logic [3:0]  x_weight_quant_size,
    output logic [3:0]  x_fea_in_quant_size,
    output logic [3:0]  x_fea_out_quant_size,
    output logic        x_stride,
    output logic [31:0] x_return_addr,
    output logic [15:0] x_return_patch_num,
    output logic [2:0]  x_padding_size,
    output logic [31:0] x_weight_data_length,
    output logic        x_activate,
    output logic [31:0] x_id,
    output logic [31:0] orders_pushed,
    output logic [15:0] err_count,
    output logic        err_pulse,
    output logic        busy
);

    state_e                  state_q, state_d;
    logic [IDX_BITS-1:0]     idx_q, idx_d;
    logic [ORDER_BITS-1:0]   sr_q, sr_d;
    logic [ORDER_BITS-1:0]   beat_word;
    order_fields_t           fields_q, fields_d, unpacked;
    logic [31:0]             orders_pushed_q;
    logic [15:0]             err_count_q;
    logic                    err_pulse_q, err_d;
    logic                    tag_ok;

    logic [ORDER_W-1:0]      u_order;
    logic [BASE_ADDR_W-1:0]  u_base_addr;
    logic [IN_PATCH_W-1:0]   u_in_patch;
    logic [OUT_PATCH_W-1:0]  u_out_patch;
    logic                    u_double;
    logic [PATCH_NUM_W-1:0]  u_patch_num;
    logic [ROW_W-1:0]        u_row;
    logic [COL_W-1:0]        u_col;
    logic [QUANT_W-1:0]      u_wq, u_fiq, u_foq;
    logic                    u_stride;
    logic [RET_ADDR_W-1:0]   u_ret_addr;
    logic [RET_PATCH_W-1:0]  u_ret_patch;
    logic [PADDING_W-1:0]    u_padding;
    logic [WLEN_W-1:0]       u_wlen;
    logic                    u_activate;
    logic [ID_W-1:0]         u_id;
    logic [TAG_W-1:0]        u_tag;

    // The shift register with the current beat already dropped into its slot, so the
    // final beat can be checked and unpacked in the same cycle it is accepted.
    always_comb begin
        beat_word = sr_q;
        beat_word[{idx_q, 5'd0} +: WORD_BITS] = s_word;
    end

    order_word_unpack u_unpack (
        .word_i      (beat_word),
        .order_o     (u_order),
        .base_addr_o (u_base_addr),
        .in_patch_o  (u_in_patch),
        .out_patch_o (u_out_patch),
        .double_o    (u_double),
        .patch_num_o (u_patch_num),
        .row_o       (u_row),
        .col_o       (u_col),
        .wq_o        (u_wq),
        .fiq_o       (u_fiq),
        .foq_o       (u_foq),
        .stride_o    (u_stride),
        .ret_addr_o  (u_ret_addr),
        .ret_patch_o (u_ret_patch),
        .padding_o   (u_padding),
        .wlen_o      (u_wlen),
        .activate_o  (u_activate),
        .id_o        (u_id),
        .tag_o       (u_tag)
    );

    always_comb begin
        unpacked           = '0;
        unpacked.order     = u_order;
        unpacked.base_addr = u_base_addr;
        unpacked.in_patch  = u_in_patch;
        unpacked.out_patch = u_out_patch;
        unpacked.dbl       = u_double;
        unpacked.patch_num = u_patch_num;
        unpacked.row       = u_row;
        unpacked.col       = u_col;
        unpacked.wq        = u_wq;
        unpacked.fiq       = u_fiq;
        unpacked.foq       = u_foq;
        unpacked.stride    = u_stride;
        unpacked.ret_addr  = u_ret_addr;
        unpacked.ret_patch = u_ret_patch;
        unpacked.padding   = u_padding;
        unpacked.wlen      = u_wlen;
        unpacked.activate  = u_activate;
        unpacked.id        = u_id;
    end

    assign tag_ok = !TAG_CHECK_EN || (u_tag == SYNC_TAG);

    // Reset overrides a pending push so nothing reaches the cache in the reset cycle.
    assign push_order_en = (state_q == ST_PUSH) && order_in_ready && !srst;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sr_d     = sr_q;
        fields_d = fields_q;
        err_d    = 1'b0;
        s_ready  = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    sr_d = beat_word;
                    if (s_last && idx_q != 3'd7) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else if (idx_q == 3'd7 && !s_last) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = ST_DISCARD;
                    end else if (idx_q == 3'd7) begin
                        if (tag_ok) begin
                            fields_d = unpacked;
                            state_d  = ST_PUSH;
                        end else begin
                            err_d = 1'b1;
                            idx_d = '0;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_PUSH: begin
                if (push_order_en) begin
                    idx_d   = '0;
                    state_d = ST_COLLECT;
                end
            end
            ST_DISCARD: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    idx_d   = '0;
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q         <= ST_COLLECT;
            idx_q           <= '0;
            sr_q            <= '0;
            fields_q        <= '0;
            orders_pushed_q <= '0;
            err_count_q     <= '0;
            err_pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sr_q        <= sr_d;
            fields_q    <= fields_d;
            err_pulse_q <= err_d;
            if (push_order_en) begin
                orders_pushed_q <= orders_pushed_q + 32'd1;
            end
            if (err_d && err_count_q != 16'hFFFF) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign x_order                    = fields_q.order;
    assign x_feature_input_base_addr  = fields_q.base_addr;
    assign x_feature_input_patch_num  = fields_q.in_patch;
    assign x_feature_output_patch_num = fields_q.out_patch;
    assign x_feature_double_patch     = fields_q.dbl;
    assign x_feature_patch_num        = fields_q.patch_num;
    assign x_row_size                 = fields_q.row;
    assign x_col_size                 = fields_q.col;
    assign x_weight_quant_size        = fields_q.wq;
    assign x_fea_in_quant_size        = fields_q.fiq;
    assign x_fea_out_quant_size       = fields_q.foq;
    assign x_stride                   = fields_q.stride;
    assign x_return_addr              = fields_q.ret_addr;
    assign x_return_patch_num         = fields_q.ret_patch;
    assign x_padding_size             = fields_q.padding;
    assign x_weight_data_length       = fields_q.wlen;
    assign x_activate                 = fields_q.activate;
    assign x_id                       = fields_q.id;

    assign orders_pushed = orders_pushed_q;
    assign err_count     = err_count_q;
    assign err_pulse     = err_pulse_q;
    assign busy          = !(state_q == ST_COLLECT && idx_q == '0);

endmodule

// File: tb/tb_order_stream_assembler.sv
// Bench for order_stream_assembler: tag-checking and tag-ignoring instances share stimulus;
// pushes are matched against a scoreboard of independently packed orders.
module tb_order_stream_assembler;

    typedef struct packed {
        logic [31:0] id;
        logic        act;
        logic [31:0] wlen;
        logic [2:0]  pad;
        logic [15:0] retp;
        logic [31:0] ret;
        logic        stride;
        logic [3:0]  foq;
        logic [3:0]  fiq;
        logic [3:0]  wq;
        logic [9:0]  col;
        logic [9:0]  row;
        logic [31:0] pn;
        logic        dbl;
        logic [7:0]  outp;
        logic [7:0]  inp;
        logic [31:0] base;
        logic [2:0]  ord;
    } bf_t;

    typedef struct {
        logic [7:0] tag;
        int         nbeats;
        int         last_at;
        int         rdy_delay;
        bit         push_a;
        bit         push_b;
        bit         err;
    } vec_t;

    logic        clk = 1'b0;
    logic        srst, s_valid, s_last, order_in_ready;
    logic [31:0] s_word;

    logic        s_ready, push_order_en, x_feature_double_patch, x_stride, x_activate, err_pulse, busy;
    logic [2:0]  x_order, x_padding_size;
    logic [31:0] x_feature_input_base_addr, x_feature_patch_num, x_return_addr, x_weight_data_length, x_id;
    logic [7:0]  x_feature_input_patch_num, x_feature_output_patch_num;
    logic [9:0]  x_row_size, x_col_size;
    logic [3:0]  x_weight_quant_size, x_fea_in_quant_size, x_fea_out_quant_size;
    logic [15:0] x_return_patch_num, err_count;
    logic [31:0] orders_pushed;

    logic        b_s_ready, b_push, b_double, b_stride, b_activate, b_err_pulse, b_busy;
    logic [2:0]  b_order, b_padding;
    logic [31:0] b_base, b_patch_num, b_ret_addr, b_wlen, b_id, b_orders_pushed;
    logic [7:0]  b_in_patch, b_out_patch;
    logic [9:0]  b_row, b_col;
    logic [3:0]  b_wq, b_fiq, b_foq;
    logic [15:0] b_ret_patch, b_err_count;

    logic [232:0] x_all;
    assign x_all = {x_id, x_activate, x_weight_data_length, x_padding_size, x_return_patch_num,
                    x_return_addr, x_stride, x_fea_out_quant_size, x_fea_in_quant_size,
                    x_weight_quant_size, x_col_size, x_row_size, x_feature_patch_num,
                    x_feature_double_patch, x_feature_output_patch_num, x_feature_input_patch_num,
                    x_feature_input_base_addr, x_order};

    always #5 clk = ~clk;

    order_stream_assembler #(.TAG_CHECK_EN(1'b1), .SYNC_TAG(8'hA5)) dut (
        .clk(clk), .srst(srst), .s_word(s_word), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .order_in_ready(order_in_ready), .push_order_en(push_order_en),
        .x_order(x_order), .x_feature_input_base_addr(x_feature_input_base_addr),
        .x_feature_input_patch_num(x_feature_input_patch_num),
        .x_feature_output_patch_num(x_feature_output_patch_num),
        .x_feature_double_patch(x_feature_double_patch), .x_feature_patch_num(x_feature_patch_num),
        .x_row_size(x_row_size), .x_col_size(x_col_size), .x_weight_quant_size(x_weight_quant_size),
        .x_fea_in_quant_size(x_fea_in_quant_size), .x_fea_out_quant_size(x_fea_out_quant_size),
        .x_stride(x_stride), .x_return_addr(x_return_addr), .x_return_patch_num(x_return_patch_num),
        .x_padding_size(x_padding_size), .x_weight_data_length(x_weight_data_length),
        .x_activate(x_activate), .x_id(x_id), .orders_pushed(orders_pushed),
        .err_count(err_count), .err_pulse(err_pulse), .busy(busy)
    );

    order_stream_assembler #(.TAG_CHECK_EN(1'b0), .SYNC_TAG(8'hA5)) dut_notag (
        .clk(clk), .srst(srst), .s_word(s_word), .s_valid(s_valid), .s_last(s_last),
        .s_ready(b_s_ready), .order_in_ready(order_in_ready), .push_order_en(b_push),
        .x_order(b_order), .x_feature_input_base_addr(b_base),
        .x_feature_input_patch_num(b_in_patch), .x_feature_output_patch_num(b_out_patch),
        .x_feature_double_patch(b_double), .x_feature_patch_num(b_patch_num),
        .x_row_size(b_row), .x_col_size(b_col), .x_weight_quant_size(b_wq),
        .x_fea_in_quant_size(b_fiq), .x_fea_out_quant_size(b_foq),
        .x_stride(b_stride), .x_return_addr(b_ret_addr), .x_return_patch_num(b_ret_patch),
        .x_padding_size(b_padding), .x_weight_data_length(b_wlen),
        .x_activate(b_activate), .x_id(b_id), .orders_pushed(b_orders_pushed),
        .err_count(b_err_count), .err_pulse(b_err_pulse), .busy(b_busy)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   last_push_cyc = 0;
    int   n_err_seen = 0;
    int   exp_pushed = 0;
    int   exp_b      = 0;
    int   exp_err    = 0;
    bf_t  sb[$];
    int   push_times[$];
    bf_t  mon_e;
    vec_t vt[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    task automatic fail(input string nm);
        n_checks++;
        $display("FAIL %s @%0t", nm, $time);
    endtask

    always @(negedge clk) begin
        if (push_order_en === 1'b1) begin
            push_times.push_back(cyc);
            last_push_cyc = cyc;
            if (sb.size() == 0) begin
                fail("unexpected_push");
            end else begin
                mon_e = sb.pop_front();
                chk("push_fields", 256'(x_all), 256'(mon_e));
            end
        end
        if (err_pulse === 1'b1) n_err_seen++;
    end

    function automatic bf_t rand_fields();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom();
        return r[232:0];
    endfunction

    function automatic logic [255:0] pack(input bf_t f, input logic [7:0] tag);
        logic [255:0] w;
        w = '0;
        w[2:0]     = f.ord;   w[34:3]    = f.base;  w[42:35]   = f.inp;
        w[50:43]   = f.outp;  w[51]      = f.dbl;   w[83:52]   = f.pn;
        w[93:84]   = f.row;   w[103:94]  = f.col;   w[107:104] = f.wq;
        w[111:108] = f.fiq;   w[115:112] = f.foq;   w[116]     = f.stride;
        w[148:117] = f.ret;   w[164:149] = f.retp;  w[167:165] = f.pad;
        w[199:168] = f.wlen;  w[200]     = f.act;   w[232:201] = f.id;
        w[247:233] = 15'($urandom());
        w[255:248] = tag;
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_order(input logic [255:0] w, input int nbeats, input int last_at, input bit hold);
        for (int k = 0; k < nbeats; k++) begin
            bit acc;
            int guard;
            s_valid = 1'b1;
            s_word  = w[32*(k%8) +: 32];
            s_last  = (k == last_at);
            acc     = 1'b0;
            guard   = 0;
            while (!acc && guard < 64) begin
                @(negedge clk);
                acc = s_ready;
                if (acc && k == last_at) acc_cyc = cyc;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) fail("beat_accept_timeout");
        end
        if (!hold) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bf_t          f;
        logic [255:0] w;

        //          tag    nb last rdy pushA pushB err
        vt[0] = '{8'hA5,  8,  7,  0, 1'b1, 1'b1, 1'b0};
        vt[1] = '{8'hA5,  8,  7,  3, 1'b1, 1'b1, 1'b0};
        vt[2] = '{8'h5A,  8,  7,  0, 1'b0, 1'b1, 1'b1};
        vt[3] = '{8'hA5,  8,  7,  0, 1'b1, 1'b1, 1'b0};
        vt[4] = '{8'hA5,  5,  4,  0, 1'b0, 1'b0, 1'b1};
        vt[5] = '{8'hA5,  8,  7,  0, 1'b1, 1'b1, 1'b0};
        vt[6] = '{8'hA5, 12, 11,  0, 1'b0, 1'b0, 1'b1};
        vt[7] = '{8'hA5,  8,  7,  0, 1'b1, 1'b1, 1'b0};
        vt[8] = '{8'hA5,  1,  0,  0, 1'b0, 1'b0, 1'b1};
        vt[9] = '{8'h00,  8,  7,  2, 1'b0, 1'b1, 1'b1};

        srst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_word = '0; order_in_ready = 1'b1;
        tick(3);
        srst = 1'b0;
        @(negedge clk);
        chk("rst_push", 256'(push_order_en), 256'(0));
        chk("rst_orders_pushed", 256'(orders_pushed), 256'(0));
        chk("rst_err_count", 256'(err_count), 256'(0));
        chk("rst_err_pulse", 256'(err_pulse), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_s_ready", 256'(s_ready), 256'(1));
        chk("rst_x_fields", 256'(x_all), 256'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            f = rand_fields();
            if (i == 0) begin
                f.ord = 3'd2; f.id = 32'h12345678; f.row = 10'd416;
            end
            w = pack(f, vt[i].tag);
            if (vt[i].push_a) sb.push_back(f);
            order_in_ready = (vt[i].rdy_delay == 0);
            send_order(w, vt[i].nbeats, vt[i].last_at, 1'b0);
            if (vt[i].rdy_delay > 0) begin
                tick(vt[i].rdy_delay);
                order_in_ready = 1'b1;
            end
            tick(3);
            exp_pushed += int'(vt[i].push_a);
            exp_b      += int'(vt[i].push_b);
            exp_err    += int'(vt[i].err);
            @(negedge clk);
            chk($sformatf("v%0d_orders_pushed", i), 256'(orders_pushed), 256'(exp_pushed));
            chk($sformatf("v%0d_err_count", i), 256'(err_count), 256'(exp_err));
            chk($sformatf("v%0d_err_pulses", i), 256'(n_err_seen), 256'(exp_err));
            chk($sformatf("v%0d_notag_pushed", i), 256'(b_orders_pushed), 256'(exp_b));
            chk($sformatf("v%0d_idle", i), 256'(busy), 256'(0));
            if (vt[i].push_a && vt[i].rdy_delay == 0)
                chk($sformatf("v%0d_push_latency", i), 256'(last_push_cyc), 256'(acc_cyc + 1));
            @(posedge clk); #1;
        end

        // Stall: cache not ready for 5 cycles after assembly.
        order_in_ready = 1'b0;
        f = rand_fields();
        w = pack(f, 8'hA5);
        sb.push_back(f);
        send_order(w, 8, 7, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_s_ready", 256'(s_ready), 256'(0));
            chk("stall_no_push", 256'(push_order_en), 256'(0));
            chk("stall_x_stable", 256'(x_all), 256'(f));
            @(posedge clk); #1;
        end
        order_in_ready = 1'b1;
        tick(4);
        exp_pushed++; exp_b++;
        @(negedge clk);
        chk("stall_single_push", 256'(orders_pushed), 256'(exp_pushed));
        @(posedge clk); #1;

        // Reset after three beats of an order.
        f = rand_fields();
        send_order(pack(f, 8'hA5), 3, -1, 1'b0);
        @(negedge clk);
        chk("mid_order_busy", 256'(busy), 256'(1));
        @(posedge clk); #1;
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
        @(negedge clk);
        chk("rst2_orders_pushed", 256'(orders_pushed), 256'(0));
        chk("rst2_err_count", 256'(err_count), 256'(0));
        chk("rst2_busy", 256'(busy), 256'(0));
        chk("rst2_x_fields", 256'(x_all), 256'(0));
        @(posedge clk); #1;
        exp_pushed = 0; exp_b = 0; exp_err = 0; n_err_seen = 0;

        // Reset while an assembled order waits in PUSH; ready rises in the reset cycle.
        order_in_ready = 1'b0;
        f = rand_fields();
        send_order(pack(f, 8'hA5), 8, 7, 1'b0);
        tick(2);
        srst = 1'b1;
        order_in_ready = 1'b1;
        @(negedge clk);
        chk("rst_cycle_no_push", 256'(push_order_en), 256'(0));
        @(posedge clk); #1;
        srst = 1'b0;
        tick(2);
        @(negedge clk);
        chk("rst3_orders_pushed", 256'(orders_pushed), 256'(0));
        chk("rst3_x_fields", 256'(x_all), 256'(0));
        @(posedge clk); #1;

        f = rand_fields();
        sb.push_back(f);
        send_order(pack(f, 8'hA5), 8, 7, 1'b0);
        tick(3);
        exp_pushed = 1; exp_b = 1;
        @(negedge clk);
        chk("after_rst_orders_pushed", 256'(orders_pushed), 256'(1));
        @(posedge clk); #1;

        // Ten back-to-back orders with valid held high.
        push_times.delete();
        for (int o = 0; o < 10; o++) begin
            f = rand_fields();
            f.id = 32'h0000_1000 + 32'(o);
            sb.push_back(f);
            send_order(pack(f, 8'hA5), 8, 7, 1'b1);
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick(4);
        exp_pushed += 10; exp_b += 10;
        @(negedge clk);
        chk("b2b_push_count", 256'(push_times.size()), 256'(10));
        if (push_times.size() == 10) begin
            for (int i = 1; i < 10; i++)
                chk($sformatf("b2b_spacing_%0d", i), 256'(push_times[i] - push_times[i-1]), 256'(9));
        end
        chk("b2b_orders_pushed", 256'(orders_pushed), 256'(exp_pushed));
        chk("b2b_notag_pushed", 256'(b_orders_pushed), 256'(exp_b));
        chk("b2b_err_count", 256'(err_count), 256'(0));
        chk("scoreboard_drained", 256'(sb.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
